instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Reader side of the 12-bit-address / 19-bit-word instruction memory interface. It owns the program counter, drives the memory address and captures the combinationally returned instruction word each cycle. Fetched words are buffered in a small queue and handed to decode over a valid/ready handshake, with support for branch redirect and flush. It sits between the instruction memory and the decode stage.

Parameters:
ADDR_W, 12, instruction memory address width
INSTR_W, 19, instruction word width
DEPTH, 2, fetch queue entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
imem_address  output  ADDR_W  address to instruction memory (= fetch_pc)
imem_instruction  input  INSTR_W  word at imem_address, same cycle (combinational read)
branch_valid  input  1  redirect request this cycle
branch_target  input  ADDR_W  redirect address
out_valid  output  1  head queue entry valid
out_ready  input  1  decode accepts head entry
out_instruction  output  INSTR_W  head entry instruction
out_pc  output  ADDR_W  head entry PC
queue_count  output  $clog2(DEPTH)+1  occupied entries (debug/verification)

Behaviour:
- One clock, synchronous active-high reset, all state updated on rising edge of clock.
- Reset: fetch_pc=RESET_PC, queue empty, out_valid=0, queue_count=0, out_instruction=0, out_pc=0. Reset overrides branch and handshake in the same cycle; reset mid-stream discards all queued entries.
- imem_address = fetch_pc continuously (combinational from register).
- pop = out_valid && out_ready. push = !branch_valid && (count<DEPTH || pop).
- On push: enqueue {fetch_pc, imem_instruction}; fetch_pc <= fetch_pc+1 modulo 2^ADDR_W (4095 -> 0, no flag).
- Full (count==DEPTH) with no pop: no push, fetch_pc holds, imem_address stable.
- Full with pop in same cycle: push and pop both occur, count unchanged.
- Empty: out_valid=0; out_instruction/out_pc hold last head values (don't-care to decode; bench checks only when valid).
- Branch (branch_valid=1, not reset): queue flushed (count<=0), fetch_pc<=branch_target, no push that cycle. A pop coinciding with branch completes (decode has taken the word) but the entry is discarded regardless. Next cycle: out_valid=0, imem_address=branch_target; first post-branch entry visible at out_valid two cycles after branch asserted.
- Latency: empty queue, no stall -> word at address A is visible at outputs the cycle after imem_address=A.
- Throughput: one instruction per cycle sustained while out_ready=1.
- Outputs out_valid/out_instruction/out_pc are combinational from queue head registers only (no path from out_ready or imem_instruction).
- Valid/ready rule: once out_valid=1, head entry and out_valid remain stable until popped, except on branch or reset.

Decomposition:
- Shared package: ADDR_W, INSTR_W constants; fetch_entry typedef {pc[ADDR_W], instr[INSTR_W]}.
- Sub-module fetch_queue: DEPTH-entry register FIFO (head/tail pointers, count, synchronous flush input, simultaneous push/pop when full). Top level holds PC, push/branch logic.

Test Plan:
- Reset, memory model word[i]=i+100, out_ready=1 -> cycle 1 out_valid=1, out_pc=0, out_instruction=100; then pc 1,2,3 with 101,102,103 on consecutive cycles.
- out_ready=0 from reset -> queue_count rises to 2 and holds, imem_address stops at 2, head stays pc 0/word 100; release out_ready -> pc 0,1,2 delivered with no gap or duplicate.
- Branch at steady stream, branch_target=100 -> next cycle out_valid=0, imem_address=100; following cycle out_pc=100, out_instruction=200; no pre-branch entry emitted.
- Branch with full queue and out_ready=0 -> queue_count=0 next cycle, both stale entries never appear.
- Redirect to 4094, out_ready=1 -> out_pc sequence 4094, 4095, 0, 1 with words 4194, 4195, 100, 101.
- reset asserted while queue full and branch_valid=1 -> next cycle out_valid=0, imem_address=0, queue_count=0; stream restarts at pc 0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths and the fetch-queue entry layout for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam int IFU_ADDR_W  = 12;
    localparam int IFU_INSTR_W = 19;
    localparam int IFU_DEPTH   = 2;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0]  pc;
        logic [IFU_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory, redirect and decode-handshake signals of the fetch unit.
interface instruction_fetch_unit_if
    import instruction_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = IFU_ADDR_W,
    parameter int INSTR_W = IFU_INSTR_W,
    parameter int DEPTH   = IFU_DEPTH
);

    logic [ADDR_W-1:0]      imem_address;
    logic [INSTR_W-1:0]     imem_instruction;
    logic                   branch_valid;
    logic [ADDR_W-1:0]      branch_target;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_W-1:0]     out_instruction;
    logic [ADDR_W-1:0]      out_pc;
    logic [$clog2(DEPTH):0] queue_count;

    modport master (
        output imem_address,
        input  imem_instruction,
        input  branch_valid,
        input  branch_target,
        output out_valid,
        input  out_ready,
        output out_instruction,
        output out_pc,
        output queue_count
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        output branch_valid,
        output branch_target,
        input  out_valid,
        output out_ready,
        input  out_instruction,
        input  out_pc,
        input  queue_count
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Register FIFO for fetched entries; supports push+pop when full and a flush.
module instruction_fetch_unit_fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int  DEPTH   = IFU_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  entry_t                 push_data_i,
    output entry_t                 head_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Flush rewinds the tail onto the head so the old head word stays on the outputs.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            tail_d  = head_q;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + 1'b1;
            if (pop_i)  head_d = head_q + 1'b1;
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_i && !flush_i) mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the PC, reads instruction memory and queues words for decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter int                INSTR_W  = IFU_INSTR_W,
    parameter int                DEPTH    = IFU_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                       clock,
    input logic                       reset,
    instruction_fetch_unit_if.master  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              push, pop, full;
    logic              q_valid;
    logic [CNT_W-1:0]  q_count;
    entry_t            q_head, push_entry;

    assign full       = (q_count == CNT_W'(DEPTH));
    assign pop        = q_valid && bus.out_ready;
    assign push       = !bus.branch_valid && (!full || pop);
    assign push_entry = '{pc: fetch_pc_q, instr: bus.imem_instruction};

    // A redirect wins over sequential advance; the PC wraps silently at the top.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.branch_valid) fetch_pc_d = bus.branch_target;
        else if (push)        fetch_pc_d = fetch_pc_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) fetch_pc_q <= RESET_PC;
        else       fetch_pc_q <= fetch_pc_d;
    end

    instruction_fetch_unit_fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (bus.branch_valid),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (push_entry),
        .head_o      (q_head),
        .valid_o     (q_valid),
        .count_o     (q_count)
    );

    assign bus.imem_address    = fetch_pc_q;
    assign bus.out_valid       = q_valid;
    assign bus.out_pc          = q_head.pc;
    assign bus.out_instruction = q_head.instr;
    assign bus.queue_count     = q_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus a stall/release sequence.
module tb_instruction_fetch_unit;

    localparam int AW = 12;
    localparam int IW = 19;
    localparam int DP = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    instruction_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP)) bus ();

    instruction_fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .DEPTH    (DP),
        .RESET_PC (12'd0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: word at address i is i+100.
    assign bus.imem_instruction = IW'(bus.imem_address) + IW'(100);

    typedef struct {
        logic          rst;
        logic          bv;
        logic [AW-1:0] bt;
        logic          rdy;
        logic          chk;
        logic          chkd;
        logic          ev;
        logic [AW-1:0] epc;
        logic [IW-1:0] ein;
        logic [1:0]    ecnt;
        logic [AW-1:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic bv, int bt, logic rdy, logic chk, logic chkd,
                                logic ev, int epc, int ein, int ecnt, int eaddr);
        vec_t v;
        v.rst = rst;   v.bv = bv;     v.bt = AW'(bt);   v.rdy = rdy;
        v.chk = chk;   v.chkd = chkd; v.ev = ev;
        v.epc = AW'(epc); v.ein = IW'(ein); v.ecnt = 2'(ecnt); v.eaddr = AW'(eaddr);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        bus.branch_valid  = 1'b0;
        bus.branch_target = '0;
        bus.out_ready     = 1'b0;

        // Expected fields describe the state seen before the edge that applies the inputs.
        //           rst bv  bt   rdy chk chkd ev  pc    in    cnt addr
        vecs.push_back(mk(1, 0, 0,    1, 0, 0, 0, 0,    0,    0, 0));
        vecs.push_back(mk(1, 0, 0,    1, 1, 1, 0, 0,    0,    0, 0));
        vecs.push_back(mk(0, 0, 0,    1, 1, 1, 0, 0,    0,    0, 0));
        vecs.push_back(mk(0, 0, 0,    1, 1, 1, 1, 0,    100,  1, 1));
        vecs.push_back(mk(0, 0, 0,    1, 1, 1, 1, 1,    101,  1, 2));
        vecs.push_back(mk(0, 0, 0,    1, 1, 1, 1, 2,    102,  1, 3));
        vecs.push_back(mk(0, 0, 0,    0, 1, 1, 1, 3,    103,  1, 4));
        vecs.push_back(mk(0, 0, 0,    0, 1, 1, 1, 3,    103,  2, 5));
        vecs.push_back(mk(0, 1, 100,  0, 1, 1, 1, 3,    103,  2, 5));
        vecs.push_back(mk(0, 0, 0,    1, 1, 0, 0, 0,    0,    0, 100));
        vecs.push_back(mk(0, 0, 0,    1, 1, 1, 1, 100,  200,  1, 101));
        vecs.push_back(mk(0, 1, 4094, 1, 1, 1, 1, 101,  201,  1, 102));
        vecs.push_back(mk(0, 0, 0,    1, 1, 0, 0, 0,    0,    0, 4094));
        vecs.push_back(mk(0, 0, 0,    1, 1, 1, 1, 4094, 4194, 1, 4095));
        vecs.push_back(mk(0, 0, 0,    1, 1, 1, 1, 4095, 4195, 1, 0));
        vecs.push_back(mk(0, 0, 0,    1, 1, 1, 1, 0,    100,  1, 1));
        vecs.push_back(mk(0, 0, 0,    0, 1, 1, 1, 1,    101,  1, 2));
        vecs.push_back(mk(1, 1, 55,   1, 1, 1, 1, 1,    101,  2, 3));
        vecs.push_back(mk(0, 0, 0,    1, 1, 1, 0, 0,    0,    0, 0));
        vecs.push_back(mk(0, 0, 0,    1, 1, 1, 1, 0,    100,  1, 1));
        vecs.push_back(mk(0, 0, 0,    1, 1, 1, 1, 1,    101,  1, 2));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset             = vecs[i].rst;
            bus.branch_valid  = vecs[i].bv;
            bus.branch_target = vecs[i].bt;
            bus.out_ready     = vecs[i].rdy;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
                check($sformatf("v%0d queue_count", i), 32'(bus.queue_count), 32'(vecs[i].ecnt));
                check($sformatf("v%0d imem_address", i), 32'(bus.imem_address), 32'(vecs[i].eaddr));
                if (vecs[i].chkd) begin
                    check($sformatf("v%0d out_pc", i), 32'(bus.out_pc), 32'(vecs[i].epc));
                    check($sformatf("v%0d out_instruction", i), 32'(bus.out_instruction),
                          32'(vecs[i].ein));
                end
            end
        end

        // Stall from reset: queue fills to two entries and the fetch address parks at 2.
        @(negedge clock);
        reset            = 1'b1;
        bus.branch_valid = 1'b0;
        bus.out_ready    = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            if (c >= 2) begin
                check($sformatf("stall%0d queue_count", c), 32'(bus.queue_count), 32'd2);
                check($sformatf("stall%0d imem_address", c), 32'(bus.imem_address), 32'd2);
                check($sformatf("stall%0d out_valid", c), 32'(bus.out_valid), 32'd1);
                check($sformatf("stall%0d out_pc", c), 32'(bus.out_pc), 32'd0);
                check($sformatf("stall%0d out_instruction", c), 32'(bus.out_instruction), 32'd100);
            end
        end

        // Release: pc 0,1,2 on consecutive cycles with no gap or duplicate.
        @(negedge clock);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("release%0d out_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("release%0d out_pc", k), 32'(bus.out_pc), 32'(k));
            check($sformatf("release%0d out_instruction", k), 32'(bus.out_instruction),
                  32'(k + 100));
            @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
